// File: rtl/rf_sequencer_if.sv
// Instruction handshake between the instruction source (master) and the
// register-file sequencer (slave).
interface rf_sequencer_if #(
    parameter int N           = 8,
    parameter int addressBits = 3
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [2:0]             opcode;
    logic [addressBits-1:0] rd;
    logic [addressBits-1:0] rs1;
    logic [addressBits-1:0] rs2;
    logic [N-1:0]           imm;
    logic [1:0]             alu_fn_in;

    modport master (
        output instr_valid,
        output opcode,
        output rd,
        output rs1,
        output rs2,
        output imm,
        output alu_fn_in,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  opcode,
        input  rd,
        input  rs1,
        input  rs2,
        input  imm,
        input  alu_fn_in,
        output instr_ready
    );
endinterface

// File: rtl/rf_sequencer.sv
// Register-file sequencer: takes one instruction at a time and steps the
// register-file read/write/select controls through a short fixed sequence.
module rf_sequencer #(
    parameter int N           = 8,
    parameter int addressBits = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    rf_sequencer_if.slave          instr,
    output logic [addressBits-1:0] readAddressA,
    output logic [addressBits-1:0] readAddressB,
    output logic                   selectDestinationA,
    output logic                   selectDestinationB,
    output logic [addressBits-1:0] writeAddress,
    output logic                   write_en,
    output logic [1:0]             selectSource,
    output logic [N-1:0]           imm_out,
    output logic [1:0]             alu_fn,
    output logic                   out_valid,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        OUT   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ALU   = 3'd1,
        OP_LOADI = 3'd2,
        OP_LOADX = 3'd3,
        OP_OUT   = 3'd4
    } opcode_t;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_EXT = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;

    state_t     state;
    logic [2:0] opcode_q;
    logic       ready_q;
    logic       accept;
    logic       opcode_legal;

    // Addresses 0 and 1 are the hardwired zero/ones registers.
    function automatic logic rd_writable(input logic [addressBits-1:0] a);
        return a > addressBits'(1);
    endfunction

    assign instr.instr_ready = ready_q;
    assign accept            = instr.instr_valid && ready_q;
    assign opcode_legal      = instr.opcode <= OP_OUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            opcode_q           <= '0;
            ready_q            <= 1'b1;
            readAddressA       <= '0;
            readAddressB       <= '0;
            writeAddress       <= '0;
            imm_out            <= '0;
            alu_fn             <= '0;
            selectDestinationA <= 1'b0;
            selectDestinationB <= 1'b0;
            write_en           <= 1'b0;
            selectSource       <= SRC_ALU;
            out_valid          <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        // Illegal opcodes leave every held field untouched.
                        if (opcode_legal) begin
                            opcode_q     <= instr.opcode;
                            readAddressA <= instr.rs1;
                            readAddressB <= instr.rs2;
                            writeAddress <= instr.rd;
                            imm_out      <= instr.imm;
                            alu_fn       <= instr.alu_fn_in;
                        end
                        case (instr.opcode)
                            OP_NOP: done <= 1'b1;
                            OP_ALU: begin
                                state              <= READ;
                                selectDestinationA <= 1'b0;
                                selectDestinationB <= 1'b0;
                                write_en           <= 1'b0;
                            end
                            OP_LOADI: begin
                                state        <= WRITE;
                                write_en     <= rd_writable(instr.rd);
                                selectSource <= SRC_IMM;
                                done         <= 1'b1;
                                err          <= !rd_writable(instr.rd);
                            end
                            OP_LOADX: begin
                                state        <= WRITE;
                                write_en     <= rd_writable(instr.rd);
                                selectSource <= SRC_EXT;
                                done         <= 1'b1;
                                err          <= !rd_writable(instr.rd);
                            end
                            OP_OUT: begin
                                state              <= OUT;
                                selectDestinationA <= 1'b1;
                                out_valid          <= 1'b1;
                                done               <= 1'b1;
                            end
                            default: begin
                                done <= 1'b1;
                                err  <= 1'b1;
                            end
                        endcase
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                READ: begin
                    state        <= WRITE;
                    write_en     <= (opcode_q == OP_ALU) && rd_writable(writeAddress);
                    selectSource <= SRC_ALU;
                    done         <= 1'b1;
                    err          <= !rd_writable(writeAddress);
                end
                WRITE, OUT: begin
                    // Return to IDLE; instr_ready reappears the cycle after done.
                    state              <= IDLE;
                    ready_q            <= 1'b1;
                    write_en           <= 1'b0;
                    selectSource       <= SRC_ALU;
                    selectDestinationA <= 1'b0;
                    selectDestinationB <= 1'b0;
                    out_valid          <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
